// File: rtl/rtc_sched_pkg.sv
// rtc_sched_pkg: shared definitions for the RTC access scheduler.
//   - FSM state encoding and operation-type encoding
//   - default READ_PERIOD / TIMEOUT_CYC values
//   - time/date field widths
//   - pick_op(): fixed-priority selection among pending requests
package rtc_sched_pkg;

  localparam int TIME_W          = 24;
  localparam int DATE_W          = 32;
  localparam int READ_PERIOD_DEF = 15_000_000;
  localparam int TIMEOUT_CYC_DEF = 1_000_000;

  typedef enum logic [1:0] {IDLE, WAIT_SET, WAIT_READ} state_t;
  typedef enum logic [1:0] {OP_TIME, OP_DATE, OP_READ} op_t;

  // Time beats date beats read. Only meaningful when something is pending;
  // with nothing set in pt/pd the caller must know a read is pending.
  function automatic op_t pick_op(input logic pt, input logic pd);
    if (pt) return OP_TIME;
    if (pd) return OP_DATE;
    return OP_READ;
  endfunction

endpackage

// File: rtl/rtc_period_timer.sv
// rtc_period_timer: free-running period counter for periodic RTC reads.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   en        : count enable; counter is held at 0 while low
//   tc        : high in the cycle the counter sits at PERIOD-1 (while enabled)
module rtc_period_timer
  import rtc_sched_pkg::*;
#(
  parameter int PERIOD = READ_PERIOD_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tc
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_reg;

  assign tc = en && (cnt_reg == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        cnt_reg <= '0;
    else if (!en)     cnt_reg <= '0;
    else if (tc)      cnt_reg <= '0;
    else              cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/rtc_access_sched.sv
// rtc_access_sched: serializes set-time, set-date and read requests onto the
// single command port of the PCF8563 I2C controller.
// Ports:
//   clk, rstn                        : clock, asynchronous active-low reset
//   set_time_req/time_in             : set-time request pulse + BCD time
//   set_date_req/date_in             : set-date request pulse + BCD date
//   read_en, read_now                : periodic read enable, forced read pulse
//   ctrl_set_time/ctrl_set_date/ctrl_read : one-cycle strobes to controller
//   ctrl_time, ctrl_date             : data words, held from strobe to next issue
//   ctrl_set_done, ctrl_read_done    : completion pulses from controller
//   busy                             : transaction outstanding
//   set_ack, read_ok, timeout_err    : one-cycle status pulses
//   err_cnt                          : saturating timeout count
// Build option: define RTC_SET_RETRY_EN to re-issue a timed-out set once.
module rtc_access_sched
  import rtc_sched_pkg::*;
#(
  parameter int READ_PERIOD = READ_PERIOD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              set_time_req,
  input  logic [TIME_W-1:0] time_in,
  input  logic              set_date_req,
  input  logic [DATE_W-1:0] date_in,
  input  logic              read_en,
  input  logic              read_now,
  output logic              ctrl_set_time,
  output logic              ctrl_set_date,
  output logic              ctrl_read,
  output logic [TIME_W-1:0] ctrl_time,
  output logic [DATE_W-1:0] ctrl_date,
  input  logic              ctrl_set_done,
  input  logic              ctrl_read_done,
  output logic              busy,
  output logic              set_ack,
  output logic              read_ok,
  output logic              timeout_err,
  output logic [7:0]        err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  state_t            state_reg;
  logic              pend_t_reg, pend_d_reg, pend_r_reg;
  logic [TIME_W-1:0] time_buf_reg;
  logic [DATE_W-1:0] date_buf_reg;
  logic [TW-1:0]     tcnt_reg;
`ifdef RTC_SET_RETRY_EN
  op_t               op_reg;
  logic              retried_reg;
`endif

  logic period_tc;
  logic any_pend, issue, iss_t, iss_d, iss_r, done_hit, tmo;
  op_t  next_op;

  rtc_period_timer #(.PERIOD(READ_PERIOD)) u_period (
    .clk  (clk),
    .rstn (rstn),
    .en   (read_en),
    .tc   (period_tc)
  );

  assign any_pend = pend_t_reg | pend_d_reg | pend_r_reg;
  assign next_op  = pick_op(pend_t_reg, pend_d_reg);
  assign issue    = (state_reg == IDLE) && any_pend;
  assign iss_t    = issue && (next_op == OP_TIME);
  assign iss_d    = issue && (next_op == OP_DATE);
  assign iss_r    = issue && (next_op == OP_READ);
  // Only the done matching the outstanding type completes it.
  assign done_hit = ((state_reg == WAIT_SET)  && ctrl_set_done) ||
                    ((state_reg == WAIT_READ) && ctrl_read_done);
  assign tmo      = (state_reg != IDLE) && !done_hit &&
                    (tcnt_reg == TW'(TIMEOUT_CYC - 1));
  assign busy     = (state_reg != IDLE);

  // A request in the same cycle its type issues re-arms the flag, so it is
  // treated as a fresh pending entry rather than merged into the issued one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_t_reg   <= 1'b0;
      pend_d_reg   <= 1'b0;
      pend_r_reg   <= 1'b0;
      time_buf_reg <= '0;
      date_buf_reg <= '0;
    end else begin
      pend_t_reg <= set_time_req | (pend_t_reg & ~iss_t);
      pend_d_reg <= set_date_req | (pend_d_reg & ~iss_d);
      pend_r_reg <= read_now | period_tc | (pend_r_reg & ~iss_r);
      if (set_time_req) time_buf_reg <= time_in;
      if (set_date_req) date_buf_reg <= date_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      tcnt_reg      <= '0;
      ctrl_set_time <= 1'b0;
      ctrl_set_date <= 1'b0;
      ctrl_read     <= 1'b0;
      ctrl_time     <= '0;
      ctrl_date     <= '0;
      set_ack       <= 1'b0;
      read_ok       <= 1'b0;
      timeout_err   <= 1'b0;
      err_cnt       <= '0;
`ifdef RTC_SET_RETRY_EN
      op_reg        <= OP_TIME;
      retried_reg   <= 1'b0;
`endif
    end else begin
      ctrl_set_time <= 1'b0;
      ctrl_set_date <= 1'b0;
      ctrl_read     <= 1'b0;
      set_ack       <= 1'b0;
      read_ok       <= 1'b0;
      timeout_err   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_pend) begin
            tcnt_reg <= '0;
`ifdef RTC_SET_RETRY_EN
            op_reg      <= next_op;
            retried_reg <= 1'b0;
`endif
            case (next_op)
              OP_TIME: begin
                ctrl_set_time <= 1'b1;
                ctrl_time     <= time_buf_reg;
                state_reg     <= WAIT_SET;
              end
              OP_DATE: begin
                ctrl_set_date <= 1'b1;
                ctrl_date     <= date_buf_reg;
                state_reg     <= WAIT_SET;
              end
              default: begin
                ctrl_read <= 1'b1;
                state_reg <= WAIT_READ;
              end
            endcase
          end
        end
        WAIT_SET, WAIT_READ: begin
          if (done_hit) begin
            if (state_reg == WAIT_SET) set_ack <= 1'b1;
            else                       read_ok <= 1'b1;
            state_reg <= IDLE;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`ifdef RTC_SET_RETRY_EN
            // One re-strobe of the same word, held in ctrl_time/ctrl_date.
            if ((state_reg == WAIT_SET) && !retried_reg) begin
              retried_reg   <= 1'b1;
              tcnt_reg      <= '0;
              ctrl_set_time <= (op_reg == OP_TIME);
              ctrl_set_date <= (op_reg == OP_DATE);
            end else begin
              state_reg <= IDLE;
            end
`else
            state_reg <= IDLE;
`endif
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_access_sched.sv
// tb_rtc_access_sched: directed scenarios followed by a random phase, all
// checked every cycle against a transaction-level reference model.
module tb_rtc_access_sched;

  localparam int RP = 100;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        set_time_req = 1'b0, set_date_req = 1'b0;
  logic [23:0] time_in = '0;
  logic [31:0] date_in = '0;
  logic        read_en = 1'b0, read_now = 1'b0;
  logic        ctrl_set_done = 1'b0, ctrl_read_done = 1'b0;
  logic        ctrl_set_time, ctrl_set_date, ctrl_read;
  logic [23:0] ctrl_time;
  logic [31:0] ctrl_date;
  logic        busy, set_ack, read_ok, timeout_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  rtc_access_sched #(.READ_PERIOD(RP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn),
    .set_time_req(set_time_req), .time_in(time_in),
    .set_date_req(set_date_req), .date_in(date_in),
    .read_en(read_en), .read_now(read_now),
    .ctrl_set_time(ctrl_set_time), .ctrl_set_date(ctrl_set_date), .ctrl_read(ctrl_read),
    .ctrl_time(ctrl_time), .ctrl_date(ctrl_date),
    .ctrl_set_done(ctrl_set_done), .ctrl_read_done(ctrl_read_done),
    .busy(busy), .set_ack(set_ack), .read_ok(read_ok),
    .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  int cmp_cnt = 0, bad_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending set per type, latest-value buffers, one
  // outstanding op with a count of wait cycles since its strobe.
  bit          m_pt, m_pd, m_pr, m_busy, m_retry;
  int          m_kind, m_wt, m_pc, m_err;
  logic [23:0] m_vt, m_ct;
  logic [31:0] m_vd, m_cd;

  // Responder: done returned N cycles after a strobe (0 = never answer).
  int set_dly = 0, read_dly = 0, rs_cnt = 0, rr_cnt = 0;
  bit rand_resp = 0;
  int n_st = 0, n_sd = 0, n_rd = 0, n_ack = 0, n_ok = 0, n_to = 0;

  function automatic int pick_dly();
    if ($urandom_range(15) == 0) return 0;
    return int'($urandom_range(20, 1));
  endfunction

  task automatic model_reset();
    m_pt = 0; m_pd = 0; m_pr = 0; m_busy = 0; m_retry = 0;
    m_kind = 0; m_wt = 0; m_pc = 0; m_err = 0;
    m_vt = '0; m_ct = '0; m_vd = '0; m_cd = '0;
  endtask

  task automatic step();
    logic c_rstn, c_rt, c_rd_req, c_rn, c_ren, c_sd, c_rdn;
    logic [23:0] c_tv;
    logic [31:0] c_dv;
    logic [6:0]  e;
    bit tick, hit;
    c_rstn = rstn; c_rt = set_time_req; c_tv = time_in; c_rd_req = set_date_req;
    c_dv = date_in; c_rn = read_now; c_ren = read_en;
    c_sd = ctrl_set_done; c_rdn = ctrl_read_done;
    @(posedge clk); #1;
    e = '0;  // {st, sd, rd, ack, ok, to, busy}
    if (!c_rstn) model_reset();
    else begin
      tick = 0;
      if (c_ren) begin
        if (m_pc == RP - 1) begin tick = 1; m_pc = 0; end
        else m_pc++;
      end else m_pc = 0;
      if (m_busy) begin
        m_wt++;
        hit = (m_kind == 2) ? c_rdn : c_sd;
        if (hit) begin
          if (m_kind == 2) e[2] = 1; else e[3] = 1;
          m_busy = 0;
        end else if (m_wt == TO) begin
          e[1] = 1;
          if (m_err < 255) m_err++;
`ifdef RTC_SET_RETRY_EN
          if (m_kind != 2 && !m_retry) begin
            m_retry = 1; m_wt = 0;
            if (m_kind == 0) e[6] = 1; else e[5] = 1;
          end else m_busy = 0;
`else
          m_busy = 0;
`endif
        end
      end else if (m_pt || m_pd || m_pr) begin
        m_busy = 1; m_wt = 0; m_retry = 0;
        if (m_pt)      begin m_kind = 0; m_pt = 0; e[6] = 1; m_ct = m_vt; end
        else if (m_pd) begin m_kind = 1; m_pd = 0; e[5] = 1; m_cd = m_vd; end
        else           begin m_kind = 2; m_pr = 0; e[4] = 1; end
      end
      if (c_rt)     begin m_pt = 1; m_vt = c_tv; end
      if (c_rd_req) begin m_pd = 1; m_vd = c_dv; end
      if (c_rn || tick) m_pr = 1;
      e[0] = m_busy;
    end
    chk("outputs", {25'd0, ctrl_set_time, ctrl_set_date, ctrl_read, set_ack, read_ok, timeout_err, busy},
        {25'd0, e});
    chk("err_cnt", {24'd0, err_cnt}, m_err);
    chk("ctrl_time", {8'd0, ctrl_time}, {8'd0, m_ct});
    chk("ctrl_date", ctrl_date, m_cd);
    n_st += int'(ctrl_set_time); n_sd += int'(ctrl_set_date); n_rd += int'(ctrl_read);
    n_ack += int'(set_ack); n_ok += int'(read_ok); n_to += int'(timeout_err);
    set_time_req = 0; set_date_req = 0; read_now = 0;
    ctrl_set_done = 0; ctrl_read_done = 0;
    if (!rstn) begin rs_cnt = 0; rr_cnt = 0; end
    if (rs_cnt > 0) begin rs_cnt--; if (rs_cnt == 0) ctrl_set_done = 1; end
    if (rr_cnt > 0) begin rr_cnt--; if (rr_cnt == 0) ctrl_read_done = 1; end
    if (ctrl_set_time || ctrl_set_date) rs_cnt = rand_resp ? pick_dly() : set_dly;
    if (ctrl_read) rr_cnt = rand_resp ? pick_dly() : read_dly;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int base, base2, exp_err;

  initial begin
    model_reset();
    // Reset state
    run(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    rstn = 1;
    run(5);

    // Periodic reads, done 10 cycles after each strobe
    read_dly = 10; read_en = 1; base = n_rd; base2 = n_ok;
    run(320);
    chk("periodic_reads", n_rd - base, 3);
    chk("periodic_read_ok", n_ok - base2, 3);
    chk("periodic_err_cnt", {24'd0, err_cnt}, 0);
    read_en = 0;
    run(20);

    // Time and date requested in the same cycle: time first, then date
    set_dly = 5; base = n_ack;
    set_time_req = 1; time_in = 24'h123045;
    set_date_req = 1; date_in = 32'h20240315;
    run(40);
    chk("same_cycle_acks", n_ack - base, 2);
    chk("same_cycle_time", {8'd0, ctrl_time}, 32'h00123045);
    chk("same_cycle_date", ctrl_date, 32'h20240315);

    // Two set_time requests during a read: one strobe with the latest value
    read_dly = 15; read_now = 1;
    step(); step();
    base = n_st;
    set_time_req = 1; time_in = 24'h010203; step(); step();
    set_time_req = 1; time_in = 24'h040506; step();
    run(40);
    chk("coalesced_strobes", n_st - base, 1);
    chk("coalesced_time", {8'd0, ctrl_time}, 32'h00040506);

    // Set that is never answered
    set_dly = 0; base = n_ack;
    set_time_req = 1; time_in = 24'h0A0B0C;
    run(120);
`ifdef RTC_SET_RETRY_EN
    exp_err = 2;
`else
    exp_err = 1;
`endif
    chk("set_timeout_err_cnt", {24'd0, err_cnt}, exp_err);
    chk("set_timeout_no_ack", n_ack - base, 0);
    // Read that is never answered (never retried)
    read_dly = 0; read_now = 1;
    run(60);
    exp_err++;
    chk("read_timeout_err_cnt", {24'd0, err_cnt}, exp_err);

    // Stray dones in WAIT_READ and in IDLE
    read_dly = 10; read_now = 1;
    run(3);
    ctrl_set_done = 1; step();
    run(15);
    ctrl_set_done = 1; ctrl_read_done = 1; step();
    run(3);

    // Done on the terminal timeout cycle wins
    set_dly = 49; base = n_ack; set_date_req = 1; date_in = 32'h19991231;
    run(60);
    chk("edge_done_ack", n_ack - base, 1);
    chk("edge_done_err_cnt", {24'd0, err_cnt}, exp_err);

    // Asynchronous reset in WAIT_SET with a read pending
    set_dly = 0; set_time_req = 1; time_in = 24'h235959;
    run(3);
    read_now = 1; step(); step();
    #3 rstn = 0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_strobes", {29'd0, ctrl_set_time, ctrl_set_date, ctrl_read}, 0);
    chk("async_rst_err_cnt", {24'd0, err_cnt}, 0);
    chk("async_rst_ctrl_time", {8'd0, ctrl_time}, 0);
    step();
    rstn = 1;
    base = n_st + n_sd + n_rd;
    run(30);
    chk("post_rst_no_strobe", n_st + n_sd + n_rd - base, 0);

    // Random traffic
    rand_resp = 1;
    for (int i = 0; i < 900; i++) begin
      set_time_req = ($urandom_range(9) == 0);
      time_in      = 24'($urandom);
      set_date_req = ($urandom_range(11) == 0);
      date_in      = $urandom;
      read_now     = ($urandom_range(13) == 0);
      if ($urandom_range(31) == 0) ctrl_set_done = 1;
      if ($urandom_range(31) == 0) ctrl_read_done = 1;
      step();
    end
    run(250);
    chk("drain_idle", {31'd0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/rtc_access_sched.md
Name: rtc_access_sched

Overview:
Scheduler that owns the single command port of the PCF8563 I2C controller and serializes three requesters onto it: UART set-time requests, UART set-date requests, and periodic/forced RTC reads. It buffers and coalesces requests, issues one strobe at a time, and waits for the matching done. It also times out hung transactions and reports errors. It replaces the free-running read counter so reads can never collide with set operations.

Parameters:
READ_PERIOD, 15_000_000, cycles between periodic read requests (≥2)
TIMEOUT_CYC, 1_000_000, max cycles waiting for a done before abort (≥2)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
set_time_req  in  1  one-cycle pulse; time_in valid same cycle
time_in  in  24  BCD hh:mm:ss to write
set_date_req  in  1  one-cycle pulse; date_in valid same cycle
date_in  in  32  BCD date word to write
read_en  in  1  enables periodic reads
read_now  in  1  one-cycle pulse forcing a read
ctrl_set_time  out  1  strobe to I2C controller
ctrl_set_date  out  1  strobe to I2C controller
ctrl_read  out  1  strobe to I2C controller
ctrl_time  out  24  time word for controller
ctrl_date  out  32  date word for controller
ctrl_set_done  in  1  controller set complete pulse
ctrl_read_done  in  1  controller read complete pulse
busy  out  1  high while a transaction is outstanding
set_ack  out  1  one-cycle pulse: set transaction finished OK
read_ok  out  1  one-cycle pulse: read finished OK
timeout_err  out  1  one-cycle pulse: transaction aborted
err_cnt  out  8  saturating timeout count

Behaviour:
- Reset: all outputs 0; pending flags, buffers, period counter, timeout counter 0; state IDLE.
- Pending flags pend_t, pend_d, pend_r are set by their request pulses.
- Buffers: time_buf and date_buf are loaded on their request pulses. A repeat request while pending overwrites the buffer; the latest value wins and only one transaction is issued.
- A request arriving while its own type is in flight becomes a new pending entry.
- Period counter:
  - When read_en=1, counts 0..READ_PERIOD-1 and wraps; at terminal count it sets pend_r.
  - When read_en=0, the counter is held at 0; an existing pend_r is kept.
  - read_now sets pend_r. Multiple read sources coalesce.
- Priority when several are pending: pend_t > pend_d > pend_r.
- States: IDLE, WAIT_SET, WAIT_READ.
- IDLE with any pend:
  - Pick the highest-priority pend and clear it.
  - For a set, copy the buffer to ctrl_time or ctrl_date.
  - Assert the matching strobe for exactly one cycle and go to WAIT_SET or WAIT_READ.
  - Latency: a request sampled at edge k while idle → strobe high during the cycle after edge k+1.
- WAIT_SET:
  - ctrl_set_done → set_ack pulse, go to IDLE.
  - ctrl_read_done is ignored.
- WAIT_READ:
  - ctrl_read_done → read_ok pulse, go to IDLE.
  - ctrl_set_done is ignored.
- Timeout:
  - The counter resets on strobe and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC-1 without the matching done: timeout_err pulse, err_cnt+1 (saturating at 255), go to IDLE.
  - A done arriving in the same cycle as terminal count wins: success, no error.
- Done pulses seen in IDLE are ignored.
- ctrl_time and ctrl_date hold stable from strobe until the next issue of the same type.
- busy = (state != IDLE).
- Back-to-back: after a done, the next pending strobe issues at the earliest on the second edge after the done edge (one IDLE cycle minimum).
- Async reset mid-transaction: immediate return to reset values; in-flight op and pends are lost; strobes low.

Optional Feature:
RTC_SET_RETRY_EN
- Defined: a set (time or date) that times out is re-issued once from the same ctrl_time/ctrl_date. timeout_err and err_cnt update on each timeout, but set_ack follows only a successful retry. A second timeout drops the op.
- Reads are never retried.
- Undefined: every timeout drops the op.

Decomposition:
- Package rtc_sched_pkg holds:
  - state encoding (IDLE, WAIT_SET, WAIT_READ)
  - op-type encoding (OP_TIME, OP_DATE, OP_READ)
  - default constants for READ_PERIOD and TIMEOUT_CYC
  - field widths 24 and 32
- One sub-module, rtc_period_timer: period counter with enable and terminal-count pulse output.

Test Plan:
- READ_PERIOD=100, read_en=1, done returned 10 cycles after each ctrl_read → ctrl_read every 100 cycles, read_ok 10 cycles later, err_cnt=0.
- set_time_req with time_in=24'h123045, and set_date_req with date_in=32'h20240315, in the same cycle → ctrl_set_time first with ctrl_time=123045; after ctrl_set_done, ctrl_set_date with ctrl_date=20240315; two set_ack pulses.
- During a pending read, set_time_req twice (first 24'h010203, then 24'h040506) while WAIT_READ → one ctrl_set_time carrying 040506, issued only after ctrl_read_done.
- TIMEOUT_CYC=50, never return done → timeout_err at strobe+50, err_cnt=1, busy falls; with RTC_SET_RETRY_EN on a set: second strobe, err_cnt=2, no set_ack.
- ctrl_set_done pulsed in WAIT_READ, and in IDLE → ignored; state and outputs unchanged.
- rstn asserted in WAIT_SET with pend_r set → all outputs 0 immediately; after release no strobe until a new request or period expiry.
